// File: rtl/cla_word_sequencer.sv
// Wide add/subtract sequencer: time-shares one WORD_W-bit carry-lookahead adder
// across NUM_WORDS slices, least-significant first, with valid/ready on both sides.
module cla_word_sequencer #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] op_a,
  input  logic [WORD_W*NUM_WORDS-1:0] op_b,
  input  logic                        cin,
  input  logic                        sub,
  output logic [WORD_W-1:0]           add_a,
  output logic [WORD_W-1:0]           add_b,
  output logic                        add_cin,
  input  logic [WORD_W-1:0]           add_sum,
  input  logic                        add_cout,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] result,
  output logic                        cout,
  output logic                        overflow,
  output logic                        zero
);

  localparam int OP_W  = WORD_W * NUM_WORDS;
  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    a_q, b_q;
  logic [OP_W-1:0]    result_q, res_upd;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               cout_q, ovf_q, zero_q;
  logic               last_slice;

  assign last_slice = (idx_q == IDX_W'(NUM_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Slice currently presented to the shared adder; idle adder sees zeros.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_q[idx_q*WORD_W +: WORD_W];
      add_b   = b_q[idx_q*WORD_W +: WORD_W];
      add_cin = carry_q;
    end
  end

  always_comb begin
    res_upd = result_q;
    res_upd[idx_q*WORD_W +: WORD_W] = add_sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b ^ {OP_W{sub}};
            carry_q  <= sub | cin;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
          end
        end
        RUN: begin
          result_q <= res_upd;
          carry_q  <= add_cout;
          if (last_slice) begin
            idx_q  <= '0;
            cout_q <= add_cout;
            // Signed overflow: same-sign operands producing an opposite-sign sum.
            ovf_q  <= (a_q[OP_W-1] == b_q[OP_W-1]) && (add_sum[WORD_W-1] != a_q[OP_W-1]);
            zero_q <= (res_upd == '0);
          end else begin
            idx_q  <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Directed bench for cla_word_sequencer with a behavioural 16-bit adder standing in
// for the shared CLA datapath.
module tb_cla_word_sequencer;

  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 4;
  localparam int OP_W      = WORD_W * NUM_WORDS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op_a, op_b;
  logic              cin, sub;
  logic [WORD_W-1:0] add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              out_valid, out_ready;
  logic [OP_W-1:0]   result;
  logic              cout, overflow, zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_cin};

  cla_word_sequencer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow), .zero(zero)
  );

  // Presents one request in IDLE, scrambles the operand inputs after acceptance,
  // and waits (bounded) for out_valid. lat counts cycles from the accept cycle.
  task automatic start_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                          input logic c, input logic s,
                          output int lat, output logic [3:0] cin_seq,
                          output logic [WORD_W-1:0] first_b, output logic accepted);
    @(negedge clk);
    accepted = in_ready;
    op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 64'hDEAD_BEEF_CAFE_F00D; op_b = 64'h0123_4567_89AB_CDEF; cin = ~c; sub = ~s;
    lat = 1; cin_seq = '0; first_b = '0;
    while (!out_valid && lat < 20) begin
      if (lat <= 4) cin_seq[lat-1] = add_cin;
      if (lat == 1) first_b = add_b;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if ({cout, overflow, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b want=000", {cout, overflow, zero}); end
    checks++; if ({add_a, add_b, add_cin} !== 33'h0) begin errors++; $display("FAIL reset_adder_if got=%h/%h/%b want=0", add_a, add_b, add_cin); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_add_basic();
    int lat; logic [3:0] cs; logic [WORD_W-1:0] fb; logic acc;
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, lat, cs, fb, acc);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL add_accept got=%b want=1", acc); end
    checks++; if (lat != 5) begin errors++; $display("FAIL add_latency got=%0d want=5", lat); end
    checks++; if (cs !== 4'b0010) begin errors++; $display("FAIL add_cin_seq got=%b want=0010", cs); end
    checks++; if (result !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL add_result got=%h want=0000000000010000", result); end
    checks++; if ({cout, overflow, zero} !== 3'b000) begin errors++; $display("FAIL add_flags got=%b want=000", {cout, overflow, zero}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL add_done_in_ready got=%b want=0", in_ready); end
    release_result();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL add_release got=%b want=10", {in_ready, out_valid}); end
  endtask

  task automatic test_full_ripple();
    int lat; logic [3:0] cs; logic [WORD_W-1:0] fb; logic acc;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, lat, cs, fb, acc);
    checks++; if (cs !== 4'b1111) begin errors++; $display("FAIL ripple_cin_seq got=%b want=1111", cs); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL ripple_result got=%h want=0", result); end
    checks++; if ({cout, overflow, zero} !== 3'b101) begin errors++; $display("FAIL ripple_flags got=%b want=101", {cout, overflow, zero}); end
    release_result();
  endtask

  task automatic test_subtract();
    int lat; logic [3:0] cs; logic [WORD_W-1:0] fb; logic acc;
    start_op(64'h5, 64'h7, 1'b0, 1'b1, lat, cs, fb, acc);
    checks++; if (fb !== 16'hFFF8) begin errors++; $display("FAIL sub_first_b got=%h want=fff8", fb); end
    checks++; if (cs[0] !== 1'b1) begin errors++; $display("FAIL sub_first_cin got=%b want=1", cs[0]); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL sub_result got=%h want=fffffffffffffffe", result); end
    checks++; if ({cout, overflow, zero} !== 3'b000) begin errors++; $display("FAIL sub_flags got=%b want=000", {cout, overflow, zero}); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat; logic [3:0] cs; logic [WORD_W-1:0] fb; logic acc;
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, lat, cs, fb, acc);
    checks++; if (result !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL ovf_result got=%h want=8000000000000000", result); end
    checks++; if ({cout, overflow, zero} !== 3'b010) begin errors++; $display("FAIL ovf_flags got=%b want=010", {cout, overflow, zero}); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic [3:0] cs; logic [WORD_W-1:0] fb; logic acc; int n;
    start_op(64'h1, 64'h2, 1'b0, 1'b0, lat, cs, fb, acc);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got=%b want=1", out_valid); end
    op_a = 64'd10; op_b = 64'd20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, result, cout, overflow, zero} !== {2'b01, 64'd3, 3'b000}) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got rdy=%b vld=%b res=%h flags=%b want rdy=0 vld=1 res=3 flags=000",
                 i, in_ready, out_valid, result, {cout, overflow, zero});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release got=%b want=10", {in_ready, out_valid}); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept in_ready got=%b want=0", in_ready); end
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_second_latency got=%0d want=4", n); end
    checks++; if (result !== 64'd30) begin errors++; $display("FAIL bp_second_result got=%h want=1e", result); end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    int lat; logic [3:0] cs; logic [WORD_W-1:0] fb; logic acc; int seen;
    @(negedge clk);
    op_a = 64'hFFFF_FFFF_FFFF_FFFF; op_b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL abort_state got=%b want=10", {in_ready, out_valid}); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL abort_result got=%h want=0", result); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_valid got=%0d want=0", seen); end
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0, lat, cs, fb, acc);
    checks++; if (lat != 5) begin errors++; $display("FAIL after_abort_latency got=%0d want=5", lat); end
    checks++; if (result !== 64'h2345_6789_ABCD_F001) begin errors++; $display("FAIL after_abort_result got=%h want=23456789abcdf001", result); end
    release_result();
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    test_reset();
    test_add_basic();
    test_full_ripple();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
